// File: rtl/booth_mult_seq.sv
// booth_mult_seq: iterative signed Booth multiplier with start/ready/done handshake.
// Computes one WIDTH x WIDTH two's-complement product over ITER cycles and holds it.
// Compile-time option: define BOOTH_RADIX4_EN for modified-Booth (radix-4) recoding,
// which halves ITER to WIDTH/2 (WIDTH must then be even). Default build is radix-2.
module booth_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    // Accumulator carries two guard bits so that +/-2M and every partial sum fit.
    localparam int AW   = WIDTH + 2;
`ifdef BOOTH_RADIX4_EN
    localparam int ITER = WIDTH / 2;
`else
    localparam int ITER = WIDTH;
`endif
    localparam int CW   = (ITER > 2) ? $clog2(ITER) : 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [AW-1:0]        m_q, m_d;
    logic [AW-1:0]        acc_q, acc_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic                 qm1_q, qm1_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 done_q, done_d;

    logic [AW-1:0]        addend_s;
    logic [AW-1:0]        sum_s;
    logic [AW-1:0]        acc_sh_s;
    logic [WIDTH-1:0]     q_sh_s;
    logic                 qm1_sh_s;

    // One Booth step: recode the low multiplier bits, add, then arithmetic shift {acc, Q, q-1}.
    always_comb begin
        addend_s = {AW{1'b0}};
`ifdef BOOTH_RADIX4_EN
        case ({q_q[1], q_q[0], qm1_q})
            3'b001, 3'b010: addend_s = m_q;
            3'b011:         addend_s = m_q << 1;
            3'b100:         addend_s = {AW{1'b0}} - (m_q << 1);
            3'b101, 3'b110: addend_s = {AW{1'b0}} - m_q;
            default:        addend_s = {AW{1'b0}};
        endcase
        sum_s    = acc_q + addend_s;
        acc_sh_s = {{2{sum_s[AW-1]}}, sum_s[AW-1:2]};
        q_sh_s   = {sum_s[1:0], q_q[WIDTH-1:2]};
        qm1_sh_s = q_q[1];
`else
        case ({q_q[0], qm1_q})
            2'b01:   addend_s = m_q;
            2'b10:   addend_s = {AW{1'b0}} - m_q;
            default: addend_s = {AW{1'b0}};
        endcase
        sum_s    = acc_q + addend_s;
        acc_sh_s = {sum_s[AW-1], sum_s[AW-1:1]};
        q_sh_s   = {sum_s[0], q_q[WIDTH-1:1]};
        qm1_sh_s = q_q[0];
`endif
    end

    // Next-state and datapath control: accept in IDLE, iterate in RUN, publish on the last step.
    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        acc_d     = acc_q;
        q_d       = q_q;
        qm1_d     = qm1_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    m_d     = {{2{multiplicand[WIDTH-1]}}, multiplicand};
                    acc_d   = {AW{1'b0}};
                    q_d     = multiplier;
                    qm1_d   = 1'b0;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                acc_d = acc_sh_s;
                q_d   = q_sh_s;
                qm1_d = qm1_sh_s;
                if (cnt_q == CW'(ITER - 1)) begin
                    state_d   = IDLE;
                    product_d = {acc_sh_s[WIDTH-1:0], q_sh_s};
                    done_d    = 1'b1;
                    cnt_d     = {CW{1'b0}};
                end else begin
                    state_d = RUN;
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            m_q       <= {AW{1'b0}};
            acc_q     <= {AW{1'b0}};
            q_q       <= {WIDTH{1'b0}};
            qm1_q     <= 1'b0;
            cnt_q     <= {CW{1'b0}};
            product_q <= {(2*WIDTH){1'b0}};
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            qm1_q     <= qm1_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

    // Outputs are direct decodes of registered state, so they are glitch-free.
    assign ready   = (state_q == IDLE);
    assign busy    = (state_q == RUN);
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq (WIDTH=8) using a scoreboard queue.
module tb_booth_mult_seq;

`ifdef BOOTH_RADIX4_EN
    localparam int ITER = 4;
`else
    localparam int ITER = 8;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  multiplicand;
    logic [7:0]  multiplier;
    logic        ready;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] exp_q[$];

    booth_mult_seq #(.WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .ready        (ready),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic signed [15:0] sa;
        logic signed [15:0] sb;
        sa = 16'(signed'(a));
        sb = 16'(signed'(b));
        return 16'(sa * sb);
    endfunction

    // Drive one accept edge (caller ensures ready), push expectation, scramble operands.
    task automatic accept(input logic [7:0] m, input logic [7:0] q, input bit push);
        start = 1'b1;
        multiplicand = m;
        multiplier = q;
        if (push) exp_q.push_back(ref_mul(m, q));
        @(posedge clk); #1;
        start = 1'b0;
        multiplicand = 8'($urandom);
        multiplier = 8'($urandom);
    endtask

    // Wait (bounded) for done; report cycles elapsed and busy-high cycles before it.
    task automatic wait_done(output int cyc, output int busy_cyc, output bit to);
        cyc = 0; busy_cyc = 0; to = 1'b0;
        while (done !== 1'b1) begin
            @(posedge clk); #1;
            cyc++;
            if (busy === 1'b1) busy_cyc++;
            if (cyc > 40) begin
                to = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; multiplicand = 8'h00; multiplier = 8'h00;
        #12;
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", ready); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
        n_cmp++; if (product !== 16'h0000) begin n_bad++; $display("FAIL reset_product got %h want 0000", product); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic;
        int cyc; int bc; bit to; logic [15:0] e;
        accept(8'd7, 8'hFD, 1'b1);
        n_cmp++; if (busy !== 1'b1 || ready !== 1'b0) begin n_bad++; $display("FAIL basic_busy_after_accept got busy=%b ready=%b want 1/0", busy, ready); end
        wait_done(cyc, bc, to);
        n_cmp++; if (to) begin n_bad++; $display("FAIL basic_timeout got no done want done"); end
        n_cmp++; if (cyc != ITER) begin n_bad++; $display("FAIL basic_latency got %0d want %0d", cyc, ITER); end
        n_cmp++; if (bc != ITER - 1) begin n_bad++; $display("FAIL basic_busy_cycles got %0d want %0d", bc, ITER - 1); end
        e = exp_q.pop_front();
        n_cmp++; if (product !== e || product !== 16'hFFEB) begin n_bad++; $display("FAIL basic_product got %h want %h", product, e); end
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL basic_ready_in_done got %b want 1", ready); end
        @(posedge clk); #1;
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL basic_done_pulse got %b want 0", done); end
    endtask

    task automatic test_corners;
        logic [7:0]  ms [3] = '{8'h80, 8'h80, 8'h00};
        logic [7:0]  qs [3] = '{8'h80, 8'h7F, 8'hFF};
        logic [15:0] want [3] = '{16'h4000, 16'hC080, 16'h0000};
        int cyc; int bc; bit to; logic [15:0] e;
        for (int i = 0; i < 3; i++) begin
            accept(ms[i], qs[i], 1'b1);
            wait_done(cyc, bc, to);
            e = exp_q.pop_front();
            n_cmp++; if (to || product !== want[i] || e !== want[i]) begin n_bad++; $display("FAIL corner_%0d got %h want %h", i, product, want[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_ignored_start;
        int pulses; int gotc; logic [15:0] got;
        pulses = 0; gotc = 0; got = 16'h0000;
        accept(8'd3, 8'd4, 1'b1);
        for (int c = 1; c <= 2 * ITER + 2; c++) begin
            if (c == 2) begin
                start = 1'b1; multiplicand = 8'd5; multiplier = 8'd5;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (done === 1'b1) begin
                pulses++; gotc = c; got = product;
            end
        end
        n_cmp++; if (pulses != 1) begin n_bad++; $display("FAIL ignored_done_count got %0d want 1", pulses); end
        n_cmp++; if (gotc != ITER) begin n_bad++; $display("FAIL ignored_latency got %0d want %0d", gotc, ITER); end
        n_cmp++; if (got !== exp_q.pop_front()) begin n_bad++; $display("FAIL ignored_product got %h want 000c", got); end
        n_cmp++; if (product !== 16'd12) begin n_bad++; $display("FAIL ignored_hold got %h want 000c", product); end
    endtask

    task automatic test_back_to_back;
        int cyc; int bc; bit to; logic [15:0] e;
        accept(8'd2, 8'd3, 1'b1);
        wait_done(cyc, bc, to);
        e = exp_q.pop_front();
        n_cmp++; if (to || cyc != ITER || product !== e) begin n_bad++; $display("FAIL b2b_first got %h lat %0d want %h lat %0d", product, cyc, e, ITER); end
        accept(8'hFA, 8'hFA, 1'b1);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_accept_in_done got busy=%b want 1", busy); end
        wait_done(cyc, bc, to);
        e = exp_q.pop_front();
        n_cmp++; if (to || cyc != ITER || product !== e || e !== 16'd36) begin n_bad++; $display("FAIL b2b_second got %h lat %0d want 0024 lat %0d", product, cyc, ITER); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_op;
        int cyc; int bc; bit to; int pulses; logic [15:0] e;
        pulses = 0;
        accept(8'd100, 8'd100, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) pulses++;
        end
        rst = 1'b1;
        #1;
        n_cmp++; if (product !== 16'h0000 || ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            n_bad++; $display("FAIL midrst_async got p=%h r=%b b=%b d=%b want 0000/1/0/0", product, ready, busy, done); end
        for (int c = 0; c < ITER + 2; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) pulses++;
        end
        rst = 1'b0;
        n_cmp++; if (pulses != 0) begin n_bad++; $display("FAIL midrst_no_done got %0d want 0", pulses); end
        accept(8'd100, 8'd100, 1'b1);
        wait_done(cyc, bc, to);
        e = exp_q.pop_front();
        n_cmp++; if (to || product !== e || e !== 16'd10000) begin n_bad++; $display("FAIL midrst_next got %h want 2710", product); end
        @(posedge clk); #1;
    endtask

    task automatic test_sweep;
        logic [7:0] edges [9] = '{8'h80, 8'h81, 8'hFF, 8'h00, 8'h01, 8'h7F, 8'h7E, 8'hAA, 8'h55};
        logic [7:0] m; logic [7:0] q;
        int cyc; int bc; bit to; logic [15:0] e;
        for (int k = 0; k < 81 + 200; k++) begin
            if (k < 81) begin
                m = edges[k / 9]; q = edges[k % 9];
            end else begin
                m = 8'($urandom); q = 8'($urandom);
            end
            accept(m, q, 1'b1);
            wait_done(cyc, bc, to);
            e = exp_q.pop_front();
            n_cmp++; if (to || product !== e) begin n_bad++; $display("FAIL sweep m=%h q=%h got %h want %h", m, q, product, e); end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_corners;
        test_ignored_start;
        test_back_to_back;
        test_reset_mid_op;
        test_sweep;
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
